crc32_rx_checker: RTL and testbench

- Receive-side counterpart to the team's CRC LUT generator; checks and strips the FCS on an 8-bit byte stream.
- Accumulates a reflected (lsb-first) CRC-32 over each incoming frame, including its trailing 4-byte FCS.
- Forwards the payload with the FCS removed and reports per-frame good/bad, runt and length status.
- Sits after the byte deframer on the receive path, ahead of packet buffering.

---
 rtl/crc32_rx_checker.sv | 162 ++++++++++++++++
 tb/tb_crc32_rx_checker.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_rx_checker.sv
// ---------------------------------------------------------------------------
// crc32_rx_checker
//
// Receive-side FCS checker. Runs a reflected (lsb-first) CRC-32 over every
// byte of a frame, including the trailing 4-byte FCS. It forwards the payload
// with the FCS stripped and reports per-frame status. The frame is good when
// the register equals the fixed residue after the last FCS byte.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      received byte, bit 0 first on the wire
//   in_valid     in_data valid (no backpressure, gaps allowed)
//   in_last      with in_valid: final byte of the frame (last FCS byte)
//   out_data     payload byte
//   out_valid    out_data valid
//   out_last     final payload byte
//   stat_valid   one-cycle pulse, frame status valid
//   stat_ok      CRC matched and frame is not a runt
//   stat_runt    frame was 4 bytes or shorter
//   stat_len     payload length (frame length - 4), saturating
// ---------------------------------------------------------------------------
module crc32_rx_checker #(
  parameter logic [31:0] POLY      = 32'h04C11DB7,
  parameter logic [31:0] INIT      = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE   = 32'hDEBB20E3,
  parameter int          LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 stat_valid,
  output logic                 stat_ok,
  output logic                 stat_runt,
  output logic [LEN_WIDTH-1:0] stat_len
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  localparam logic [31:0] POLY_REFL = reflect32(POLY);

  // The byte counter needs one extra bit: it counts up to 2^LEN_WIDTH+3 so
  // that the derived payload length saturates exactly at 2^LEN_WIDTH-1.
  localparam int CW = LEN_WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX  = {1'b1, {(LEN_WIDTH-2){1'b0}}, 2'b11};
  localparam logic [CW-1:0] CNT_FOUR = CW'(4);
  localparam logic [CW-1:0] CNT_THREE = CW'(3);

  function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

  state_t          state;
  logic [31:0]     crc;
  logic [CW-1:0]   cnt;
  logic [7:0]      dl [4];
  logic [3:0]      dl_vld;

  logic [31:0]     crc_next;
  logic [CW-1:0]   total_next;
  logic [CW-1:0]   len_full;
  logic [LEN_WIDTH-1:0] len_sat;
  logic            runt;

  // A new frame starts from INIT, so the incoming byte in IDLE is folded into
  // INIT rather than into whatever the previous frame left in the register.
  always_comb begin
    crc_next   = crc_byte((state == IDLE) ? INIT : crc, in_data);
    total_next = (state == IDLE) ? CW'(1)
               : ((cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1));
    runt       = (total_next <= CNT_FOUR);
    len_full   = runt ? '0 : (total_next - CNT_FOUR);
    len_sat    = len_full[LEN_WIDTH-1:0];
  end

  // Control, CRC and all registered outputs. A frame's status and the
  // first byte of the next frame may share a cycle, so the in_last branch
  // only fixes the next state and never blocks the byte being absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      crc        <= INIT;
      cnt        <= '0;
      dl_vld     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      stat_valid <= 1'b0;
      stat_ok    <= 1'b0;
      stat_runt  <= 1'b0;
      stat_len   <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      stat_valid <= 1'b0;
      if (in_valid) begin
        crc    <= crc_next;
        cnt    <= total_next;
        dl_vld <= (state == IDLE) ? 4'b0001 : {dl_vld[2:0], 1'b1};

        // Once four bytes are held, every new byte pushes the oldest out;
        // the oldest can never be part of the FCS.
        if (state == STREAM && dl_vld[3]) begin
          out_valid <= 1'b1;
          out_data  <= dl[3];
          out_last  <= in_last;
        end

        if (in_last) begin
          state      <= IDLE;
          cnt        <= '0;
          stat_valid <= 1'b1;
          stat_runt  <= runt;
          stat_ok    <= !runt && (crc_next == RESIDUE);
          stat_len   <= len_sat;
        end else begin
          case (state)
            IDLE:    state <= FILL;
            FILL:    if (cnt == CNT_THREE) state <= STREAM;
            STREAM:  state <= STREAM;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  // Delay line data is don't-care after reset; only its valid flags matter.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      dl[0] <= in_data;
      for (int i = 1; i < 4; i++) begin
        dl[i] <= dl[i-1];
      end
    end
  end

endmodule

// File: tb/tb_crc32_rx_checker.sv
// ---------------------------------------------------------------------------
// tb_crc32_rx_checker
//
// Directed self-checking bench for crc32_rx_checker. A monitor records every
// out_valid byte and every stat pulse; each test task drives one scenario and
// compares the recorded results against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_crc32_rx_checker;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        stat_valid;
  logic        stat_ok;
  logic        stat_runt;
  logic [15:0] stat_len;

  int checks;
  int errors;

  typedef struct packed {
    logic        ok;
    logic        runt;
    logic [15:0] len;
    logic        with_last;
  } stat_t;

  logic [7:0] out_q [$];
  logic       last_q [$];
  stat_t      stat_q [$];
  logic [7:0] frame_q [$];
  logic [7:0] exp_q [$];

  crc32_rx_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .stat_valid (stat_valid),
    .stat_ok    (stat_ok),
    .stat_runt  (stat_runt),
    .stat_len   (stat_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs change on the rising edge, so sample them on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        out_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (stat_valid) begin
        stat_q.push_back('{ok: stat_ok, runt: stat_runt, len: stat_len,
                           with_last: out_valid && out_last});
      end
    end
  end

  task automatic clear_logs();
    out_q.delete();
    last_q.delete();
    stat_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Idle cycles hold in_last high to show it is ignored without in_valid.
  task automatic gap(input int n);
    in_last = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_byte(frame_q[i], i == frame_q.size() - 1);
      if (gap_max > 0 && i != frame_q.size() - 1) gap(i % (gap_max + 1));
    end
  endtask

  task automatic load_good_frame();
    frame_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    exp_q   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                8'h39};
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_last !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_out_data: got last=%b data=%h want 0/00", out_last, out_data);
    end
    checks++;
    if (stat_valid !== 1'b0 || stat_ok !== 1'b0 || stat_runt !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_stat: got v=%b ok=%b runt=%b want 0/0/0", stat_valid, stat_ok, stat_runt);
    end
    checks++;
    if (stat_len !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_stat_len: got %0d want 0", stat_len);
    end
  endtask

  task automatic check_payload(input string name);
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL %s_count: got %0d want %0d", name, out_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (out_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
          errors++; $display("[TB] FAIL %s_byte%0d: got %h last=%b want %h last=%b", name, i, out_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
        end
      end
    end
  endtask

  task automatic check_stat(input string name, input int idx, input logic ok,
                            input logic runt, input logic [15:0] len);
    checks++;
    if (stat_q.size() <= idx) begin
      errors++; $display("[TB] FAIL %s_stat_present: got %0d pulses want > %0d", name, stat_q.size(), idx);
    end else if (stat_q[idx].ok !== ok || stat_q[idx].runt !== runt || stat_q[idx].len !== len ||
                 stat_q[idx].with_last !== !runt) begin
      errors++; $display("[TB] FAIL %s_stat: got ok=%b runt=%b len=%0d wl=%b want ok=%b runt=%b len=%0d wl=%b", name, stat_q[idx].ok, stat_q[idx].runt, stat_q[idx].len, stat_q[idx].with_last, ok, runt, len, !runt);
    end
  endtask

  task automatic test_good_frame();
    clear_logs();
    load_good_frame();
    send_frame(0);
    idle(4);
    check_payload("good");
    checks++;
    if (stat_q.size() != 1) begin
      errors++; $display("[TB] FAIL good_stat_count: got %0d want 1", stat_q.size());
    end
    check_stat("good", 0, 1'b1, 1'b0, 16'd9);
  endtask

  task automatic test_bad_crc();
    clear_logs();
    load_good_frame();
    frame_q[4] = 8'h34;
    exp_q[4]   = 8'h34;
    send_frame(0);
    idle(4);
    check_payload("badcrc");
    check_stat("badcrc", 0, 1'b0, 1'b0, 16'd9);
  endtask

  task automatic test_gaps();
    clear_logs();
    frame_q = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
    exp_q   = '{8'h00};
    send_frame(3);
    idle(4);
    check_payload("gaps");
    check_stat("gaps", 0, 1'b1, 1'b0, 16'd1);
  endtask

  task automatic test_runt();
    clear_logs();
    frame_q = '{8'hAA, 8'hBB, 8'hCC};
    send_frame(0);
    idle(4);
    checks++;
    if (out_q.size() != 0) begin
      errors++; $display("[TB] FAIL runt3_out_count: got %0d want 0", out_q.size());
    end
    check_stat("runt3", 0, 1'b0, 1'b1, 16'd0);
    checks++;
    if (stat_runt !== 1'b1 || stat_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL runt3_hold: got runt=%b v=%b want 1/0", stat_runt, stat_valid);
    end
    clear_logs();
    frame_q = '{8'h5A};
    send_frame(0);
    idle(3);
    check_stat("runt1", 0, 1'b0, 1'b1, 16'd0);
    checks++;
    if (out_q.size() != 0) begin
      errors++; $display("[TB] FAIL runt1_out_count: got %0d want 0", out_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    load_good_frame();
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], i == frame_q.size() - 1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h8D, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hD2, 1'b1);
    idle(4);
    checks++;
    if (out_q.size() != 10) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d want 10", out_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (out_q[i] !== exp_q[i] || last_q[i] !== (i == 8)) begin
          errors++; $display("[TB] FAIL b2b_byte%0d: got %h last=%b want %h last=%b", i, out_q[i], last_q[i], exp_q[i], i == 8);
        end
      end
      checks++;
      if (out_q[9] !== 8'h00 || last_q[9] !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_byte9: got %h last=%b want 00 last=1", out_q[9], last_q[9]);
      end
    end
    checks++;
    if (stat_q.size() != 2) begin
      errors++; $display("[TB] FAIL b2b_stat_count: got %0d want 2", stat_q.size());
    end
    check_stat("b2b_first", 0, 1'b1, 1'b0, 16'd9);
    check_stat("b2b_second", 1, 1'b1, 1'b0, 16'd1);
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    load_good_frame();
    for (int i = 0; i < 6; i++) send_byte(frame_q[i], 1'b0);
    checks++;
    if (stat_q.size() != 0) begin
      errors++; $display("[TB] FAIL midrst_partial_stat: got %0d pulses want 0", stat_q.size());
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || stat_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_async: got ov=%b sv=%b want 0/0", out_valid, stat_valid);
    end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    clear_logs();
    send_frame(0);
    idle(4);
    check_payload("midrst");
    checks++;
    if (stat_q.size() != 1) begin
      errors++; $display("[TB] FAIL midrst_stat_count: got %0d want 1", stat_q.size());
    end
    check_stat("midrst", 0, 1'b1, 1'b0, 16'd9);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_gaps();
    test_runt();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
